// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops bytes from a FIFO read port and sends them as 8N1 UART frames, LSB first.
// Define PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

`ifdef PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_shift;
  logic [BW-1:0]   r_baud;
  logic [2:0]      r_bit;
  logic            w_baud_end;
`ifdef PARITY_EN
  logic            r_parity;
`endif

  assign w_baud_end = (r_baud == BAUD_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!fifo_empty) w_next = S_FETCH;
      S_FETCH: w_next = S_LOAD;
      S_LOAD:  w_next = S_START;
      S_START: if (w_baud_end) w_next = S_DATA;
`ifdef PARITY_EN
      S_DATA:   if (w_baud_end && (r_bit == 3'd7)) w_next = S_PARITY;
      S_PARITY: if (w_baud_end) w_next = S_STOP;
`else
      S_DATA:  if (w_baud_end && (r_bit == 3'd7)) w_next = S_STOP;
`endif
      // fifo_empty is only looked at here and in IDLE; mid-frame changes are ignored
      S_STOP:  if (w_baud_end) w_next = fifo_empty ? S_IDLE : S_FETCH;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
      r_baud  <= '0;
      r_bit   <= '0;
`ifdef PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_LOAD: begin
          r_shift <= fifo_dout;
          r_baud  <= '0;
          r_bit   <= '0;
`ifdef PARITY_EN
          r_parity <= ^fifo_dout;
`endif
        end
        S_DATA: begin
          r_baud <= w_baud_end ? '0 : r_baud + BW'(1);
          if (w_baud_end) begin
            r_shift <= {1'b0, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
          end
        end
`ifdef PARITY_EN
        S_START, S_PARITY, S_STOP: r_baud <= w_baud_end ? '0 : r_baud + BW'(1);
`else
        S_START, S_STOP: r_baud <= w_baud_end ? '0 : r_baud + BW'(1);
`endif
        default: r_baud <= '0;
      endcase
    end
  end

  // Outputs decode only registered state, so an async reset forces tx high at once
  always_comb begin
    tx = 1'b1;
    case (r_state)
      S_START:  tx = 1'b0;
      S_DATA:   tx = r_shift[0];
`ifdef PARITY_EN
      S_PARITY: tx = r_parity;
`endif
      default:  tx = 1'b1;
    endcase
  end

  assign fifo_rd    = (r_state == S_FETCH);
  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_STOP) && w_baud_end;

  a_rd_not_empty: assert property (@(posedge clk) disable iff (!rst) fifo_rd |-> !fifo_empty);
  a_rd_single:    assert property (@(posedge clk) disable iff (!rst) fifo_rd |=> !fifo_rd);
  a_idle_tx_high: assert property (@(posedge clk) disable iff (!rst) (r_state == S_IDLE) |-> tx);
  a_done_tx_high: assert property (@(posedge clk) disable iff (!rst) frame_done |-> tx);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed self-checking bench for fifo_uart_tx with CLKS_PER_BIT=4.
// A behavioural FIFO (registered dout) feeds the DUT; PARITY_EN selects 11-bit frames.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FR = NB * CPB + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       force_ne;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd;
  logic       tx;
  logic       busy;
  logic       frame_done;

  logic [7:0] mem [0:15];
  int         wcnt = 0;
  int         rcnt = 0;
  int         tests = 0;
  int         fails = 0;
  logic       tx_log   [0:127];
  logic       rd_log   [0:127];
  logic       done_log [0:127];

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wcnt == rcnt) && !force_ne;

  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_dout <= mem[rcnt % 16];
      rcnt      <= rcnt + 1;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wcnt % 16] = b;
    wcnt = wcnt + 1;
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic log_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      tx_log[i]   = tx;
      rd_log[i]   = fifo_rd;
      done_log[i] = frame_done;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    force_ne = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx cyc=%0d: got %b want 1", i, tx); end
      tests++; if (fifo_rd !== 1'b0) begin fails++; $display("FAIL reset_rd cyc=%0d: got %b want 0", i, fifo_rd); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy cyc=%0d: got %b want 0", i, busy); end
      tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_done cyc=%0d: got %b want 0", i, frame_done); end
    end
    tests++; if (rcnt !== 0) begin fails++; $display("FAIL reset_pops: got %0d want 0", rcnt); end
    force_ne = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    int nd;
    nd = 0;
    push(8'hA5);
    tick();
    tests++; if (fifo_rd !== 1'b1) begin fails++; $display("FAIL single_rd_latency: got %b want 1", fifo_rd); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_fetch: got %b want 1", busy); end
    tick();
    tests++; if (fifo_rd !== 1'b0) begin fails++; $display("FAIL single_rd_pulse: got %b want 0", fifo_rd); end
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL single_tx_load: got %b want 1", tx); end
    for (int k = 0; k < NB; k++) begin
      for (int c = 0; c < CPB; c++) begin
        tick();
        if (frame_done === 1'b1) nd++;
        tests++; if (tx !== exp_bit(8'hA5, k)) begin fails++; $display("FAIL single_tx bit=%0d cyc=%0d: got %b want %b", k, c, tx, exp_bit(8'hA5, k)); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy bit=%0d cyc=%0d: got %b want 1", k, c, busy); end
      end
    end
    tests++; if (frame_done !== 1'b1) begin fails++; $display("FAIL single_done_last: got %b want 1", frame_done); end
    tests++; if (nd !== 1) begin fails++; $display("FAIL single_done_count: got %0d want 1", nd); end
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_after: got %b want 0", busy); end
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL single_tx_idle: got %b want 1", tx); end
    tests++; if (rcnt !== wcnt) begin fails++; $display("FAIL single_pops: got %0d want %0d", rcnt, wcnt); end
  endtask

  task automatic test_back_to_back();
    int nrd, r1, r2;
    nrd = 0; r1 = 0; r2 = FR;
    push(8'h00);
    push(8'hFF);
    log_cycles(120);
    for (int i = 0; i < 120; i++) begin
      if (rd_log[i] === 1'b1) begin
        if (nrd == 0) r1 = i;
        if (nrd == 1) r2 = i;
        nrd++;
      end
    end
    tests++; if (nrd !== 2) begin fails++; $display("FAIL b2b_rd_count: got %0d want 2", nrd); end
    tests++; if (r1 !== 0) begin fails++; $display("FAIL b2b_first_rd: got %0d want 0", r1); end
    tests++; if (r2 - r1 !== FR) begin fails++; $display("FAIL b2b_rd_spacing: got %0d want %0d", r2 - r1, FR); end
    for (int j = 0; j < NB * CPB; j++) begin
      tests++; if (tx_log[r1 + 2 + j] !== exp_bit(8'h00, j / CPB)) begin fails++; $display("FAIL b2b_tx0 cyc=%0d: got %b want %b", j, tx_log[r1 + 2 + j], exp_bit(8'h00, j / CPB)); end
      tests++; if (tx_log[r2 + 2 + j] !== exp_bit(8'hFF, j / CPB)) begin fails++; $display("FAIL b2b_tx1 cyc=%0d: got %b want %b", j, tx_log[r2 + 2 + j], exp_bit(8'hFF, j / CPB)); end
    end
    tests++; if (tx_log[r2] !== 1'b1 || tx_log[r2 + 1] !== 1'b1) begin fails++; $display("FAIL b2b_gap: got %b%b want 11", tx_log[r2], tx_log[r2 + 1]); end
    tests++; if (done_log[r2 - 1] !== 1'b1) begin fails++; $display("FAIL b2b_done_before_gap: got %b want 1", done_log[r2 - 1]); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle: got %b want 0", busy); end
    tests++; if (rcnt !== wcnt) begin fails++; $display("FAIL b2b_pops: got %0d want %0d", rcnt, wcnt); end
  endtask

  task automatic test_empty();
    for (int i = 0; i < 100; i++) begin
      tick();
      tests++; if (fifo_rd !== 1'b0) begin fails++; $display("FAIL empty_rd cyc=%0d: got %b want 0", i, fifo_rd); end
      tests++; if (tx !== 1'b1) begin fails++; $display("FAIL empty_tx cyc=%0d: got %b want 1", i, tx); end
    end
    tests++; if (rcnt !== wcnt) begin fails++; $display("FAIL empty_pops: got %0d want %0d", rcnt, wcnt); end
  endtask

  task automatic test_reset_mid();
    int pops;
    push(8'h3C);
    tick();
    tick();
    // LOAD seen; the 17th tick lands on the first cycle of data bit 3 (frame bit 4)
    for (int i = 0; i < 18; i++) tick();
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL mid_bit3: got %b want 1", tx); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b want 1", busy); end
    rst = 1'b0;
    #1;
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL mid_async_tx: got %b want 1", tx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_async_busy: got %b want 0", busy); end
    tick();
    tick();
    rst = 1'b1;
    pops = rcnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++; if (fifo_rd !== 1'b0) begin fails++; $display("FAIL mid_no_reread cyc=%0d: got %b want 0", i, fifo_rd); end
    end
    tests++; if (rcnt !== pops) begin fails++; $display("FAIL mid_pops_stable: got %0d want %0d", rcnt, pops); end
    push(8'h81);
    tick();
    tests++; if (fifo_rd !== 1'b1) begin fails++; $display("FAIL mid_new_pop: got %b want 1", fifo_rd); end
    tick();
    tick();
    tests++; if (tx !== 1'b0) begin fails++; $display("FAIL mid_new_start: got %b want 0", tx); end
    repeat (NB * CPB) tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_final_idle: got %b want 0", busy); end
    tests++; if (rcnt !== wcnt) begin fails++; $display("FAIL mid_final_pops: got %0d want %0d", rcnt, wcnt); end
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    int nrd, r1, r2;
    nrd = 0; r1 = 0; r2 = 46;
    push(8'h07);
    push(8'h03);
    log_cycles(120);
    for (int i = 0; i < 120; i++) begin
      if (rd_log[i] === 1'b1) begin
        if (nrd == 0) r1 = i;
        if (nrd == 1) r2 = i;
        nrd++;
      end
    end
    tests++; if (nrd !== 2) begin fails++; $display("FAIL par_rd_count: got %0d want 2", nrd); end
    tests++; if (r2 - r1 !== 46) begin fails++; $display("FAIL par_frame_len: got %0d want 46", r2 - r1); end
    for (int c = 0; c < CPB; c++) begin
      tests++; if (tx_log[r1 + 2 + 36 + c] !== 1'b1) begin fails++; $display("FAIL par_bit_07 cyc=%0d: got %b want 1", c, tx_log[r1 + 2 + 36 + c]); end
      tests++; if (tx_log[r2 + 2 + 36 + c] !== 1'b0) begin fails++; $display("FAIL par_bit_03 cyc=%0d: got %b want 0", c, tx_log[r2 + 2 + 36 + c]); end
    end
    tests++; if (done_log[r1 + 2 + 43] !== 1'b1) begin fails++; $display("FAIL par_done_pos: got %b want 1", done_log[r1 + 2 + 43]); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL par_idle: got %b want 0", busy); end
  endtask
`endif

  initial begin
    rst = 1'b0;
    force_ne = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_empty();
    test_reset_mid();
`ifdef PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for the 16-deep byte FIFO. Pops one byte at a time through the FIFO read port and serialises it as an 8N1 UART frame on a single tx line, LSB first. Reads strictly via the FIFO's empty/rd/dout handshake (dout registered, valid the cycle after rd is sampled), so no byte is ever requested from an empty FIFO.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 2..65535; bit counter width is $clog2(CLKS_PER_BIT).

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
fifo_empty  input  1  FIFO empty flag
fifo_dout  input  8  FIFO read data; valid the cycle after fifo_rd is sampled high
fifo_rd  output  1  FIFO pop strobe; single-cycle pulse per byte
tx  output  1  serial line; idle high
busy  output  1  high from FETCH until the end of STOP
frame_done  output  1  one-cycle pulse in the last cycle of STOP

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, tx=1, fifo_rd=0, busy=0, frame_done=0, shift register=0, bit/baud counters=0. Release is synchronous to the next clk edge.
- All outputs are registered or decoded from registered state only. No combinational path from fifo_empty to fifo_rd.
- States: IDLE, FETCH, LOAD, START, DATA, STOP (PARITY when PARITY_EN is defined).
- IDLE: tx=1. If fifo_empty=0 -> FETCH.
- FETCH: fifo_rd=1 for exactly this one cycle; busy=1 -> LOAD.
- LOAD: capture fifo_dout into an 8-bit shift register; baud counter cleared -> START.
- START: tx=0 for CLKS_PER_BIT cycles -> DATA.
- DATA: tx=shift[0]; after each CLKS_PER_BIT cycles, shift right and increment the bit index. After bit 7 -> STOP (or PARITY).
- STOP: tx=1 for CLKS_PER_BIT cycles; frame_done=1 in the final cycle. Then -> FETCH if fifo_empty=0, otherwise -> IDLE.
- Latency: fifo_empty falling in IDLE -> fifo_rd one cycle later -> tx falling edge 2 cycles after fifo_rd.
- Frame length: 10*CLKS_PER_BIT cycles. Back-to-back frames have 2 cycles of tx=1 (FETCH, LOAD) between the stop bit and the next start bit.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. The bit index is 3 bits and wraps 7->0 only on the DATA exit.
- fifo_empty is sampled only in IDLE and at the end of STOP. A change mid-frame has no effect.
- Simultaneous FIFO write during FETCH: irrelevant. The decision to pop was made with fifo_empty=0.
- Reset mid-frame: tx returns to 1 immediately (asynchronous). The popped byte is discarded and not re-read.
- The FIFO's own rd-when-empty guard is never relied upon. fifo_rd=1 with fifo_empty=1 is a design error and is asserted against.
- Embedded SVA (disabled while rst=0):
  - fifo_rd -> !fifo_empty.
  - fifo_rd never high two consecutive cycles.
  - tx==1 whenever state is IDLE.
  - frame_done -> tx==1.

Optional Feature:
PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame length becomes 11*CLKS_PER_BIT.
- Undefined: no PARITY state, no parity logic. Frames are 8N1 as above.

Test Plan:
All scenarios use CLKS_PER_BIT=4.
1. Reset: hold rst=0 with fifo_empty=0 -> tx=1, fifo_rd=0, busy=0 throughout; no pop occurs.
2. Single byte 0xA5: fifo_empty falls in IDLE -> one fifo_rd pulse; tx sequence 0,1,0,1,0,0,1,0,1,1, each level 4 cycles; frame_done once; busy=0 after STOP.
3. Back-to-back 0x00 then 0xFF (FIFO holds 2): exactly 2 fifo_rd pulses, 42 cycles apart; 2-cycle tx=1 gap between frames; FSM returns to IDLE once empty.
4. Empty FIFO: fifo_empty=1 for 100 cycles -> fifo_rd never asserted, tx constant 1.
5. Reset mid-frame: rst=0 during DATA bit 3 of 0x3C -> tx=1 within the same cycle; after release, the next frame starts only if fifo_empty=0, with a new pop.
6. PARITY_EN defined, byte 0x07 -> parity bit 1; byte 0x03 -> parity bit 0; frame length 44 cycles.
